kalman_sequencer: RTL and testbench

Host-side initiator for the Kalman core's start/finish handshake. It accepts accelerometer angle samples on a valid/ready stream and buffers them in a small FIFO. For each sample it holds the pair stable on the core inputs for a whole run, pulses `core_start`, waits for `core_finish` under a watchdog, and returns the core's estimates on a valid/ready output stream. It sits between the sensor front end and the Kalman core and shares the core's clock and reset.

---
 rtl/kalman_pkg.sv | 19 +
 rtl/kalman_sample_fifo.sv | 60 ++++++
 rtl/kalman_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_kalman_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman core host-side blocks.
package kalman_pkg;

    // Q2.14 sample format
    localparam int W = 16;
    localparam logic signed [W-1:0] Q_ONE = 16'sd16384;

    // Default watchdog limit in WAIT cycles
    localparam int DEFAULT_TIMEOUT = 1023;

    // Run sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

endpackage

// File: rtl/kalman_sample_fifo.sv
// Synchronous sample FIFO. The pointers carry one extra wrap bit, so
// full and empty are told apart by the MSBs. A pop reads the head
// combinationally from dout. Push while full and pop while empty are ignored.
module kalman_sample_fifo
    import kalman_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          full_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; full_next is the flag as it will look next cycle
    always_comb begin
        do_push   = push & ~full;
        do_pop    = pop & ~empty;
        wr_ptr_d  = wr_ptr_q + PW'(do_push);
        rd_ptr_d  = rd_ptr_q + PW'(do_pop);
        full_next = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer registers; a reset flushes the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/kalman_sequencer.sv
// Host-side initiator for the Kalman core start/finish handshake.
// Samples are queued, presented one at a time to the core, and the core's
// estimates are handed downstream.
//
// Both streams use valid/ready: a transfer happens in any cycle where valid
// and ready are both high at the rising edge; valid does not wait for ready.
// The input side drops (and flags) a sample offered while s_ready is low.
module kalman_sequencer
    import kalman_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int W       = kalman_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_theta,
    input  logic [W-1:0] s_phi,
    output logic         core_start,
    output logic [W-1:0] core_theta,
    output logic [W-1:0] core_phi,
    input  logic         core_finish,
    input  logic [W-1:0] core_theta_est,
    input  logic [W-1:0] core_phi_est,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_theta,
    output logic [W-1:0] m_phi,
    output logic         overflow,
    output logic         timeout_err,
    input  logic         clear_err,
    output logic         busy,
    output logic [15:0]  run_count,
    output seq_state_e   dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    core_theta_q, core_theta_d;
    logic [W-1:0]    core_phi_q, core_phi_d;
    logic            core_start_q, core_start_d;
    logic [W-1:0]    hold_theta_q, hold_theta_d;
    logic [W-1:0]    hold_phi_q, hold_phi_d;
    logic            m_valid_q, m_valid_d;
    logic [W-1:0]    m_theta_q, m_theta_d;
    logic [W-1:0]    m_phi_q, m_phi_d;
    logic            overflow_q, overflow_d;
    logic            timeout_err_q, timeout_err_d;
    logic            busy_q, busy_d;
    logic            s_ready_q, s_ready_d;
    logic [15:0]     run_count_q, run_count_d;

    logic            fifo_push;
    logic            fifo_pop;
    logic [2*W-1:0]  fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_full_next;
    logic            overflow_set;
    logic            timeout_set;

    // s_ready mirrors the FIFO full flag one cycle early, so it is a flop
    // yet never lags the real occupancy.
    assign fifo_push    = s_valid & s_ready_q;
    assign fifo_pop     = (state_q == ST_IDLE) & ~fifo_empty;
    assign overflow_set = s_valid & fifo_full;
    assign s_ready_d    = ~fifo_full_next;

    kalman_sample_fifo #(
        .DEPTH (DEPTH),
        .DW    (2 * W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       ({s_theta, s_phi}),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .full_next (fifo_full_next)
    );

    // Run sequencing, watchdog, output register and sticky flags
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_theta_d = core_theta_q;
        core_phi_d   = core_phi_q;
        hold_theta_d = hold_theta_q;
        hold_phi_d   = hold_phi_q;
        m_theta_d    = m_theta_q;
        m_phi_d      = m_phi_q;
        m_valid_d    = m_valid_q & ~m_ready;
        run_count_d  = run_count_q;
        timeout_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Core inputs only ever change here, so they stay put for a run
                if (fifo_pop) begin
                    {core_theta_d, core_phi_d} = fifo_dout;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A finish on the last allowed cycle still counts as a good run
                if (core_finish) begin
                    hold_theta_d = core_theta_est;
                    hold_phi_d   = core_phi_est;
                    state_d      = ST_DRAIN;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!m_valid_q || m_ready) begin
                    m_theta_d   = hold_theta_q;
                    m_phi_d     = hold_phi_q;
                    m_valid_d   = 1'b1;
                    run_count_d = run_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        overflow_d    = overflow_set | (overflow_q & ~clear_err);
        timeout_err_d = timeout_set | (timeout_err_q & ~clear_err);
        core_start_d  = (state_d == ST_START);
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any run in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            core_theta_q  <= '0;
            core_phi_q    <= '0;
            core_start_q  <= 1'b0;
            hold_theta_q  <= '0;
            hold_phi_q    <= '0;
            m_valid_q     <= 1'b0;
            m_theta_q     <= '0;
            m_phi_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            s_ready_q     <= 1'b0;
            run_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_theta_q  <= core_theta_d;
            core_phi_q    <= core_phi_d;
            core_start_q  <= core_start_d;
            hold_theta_q  <= hold_theta_d;
            hold_phi_q    <= hold_phi_d;
            m_valid_q     <= m_valid_d;
            m_theta_q     <= m_theta_d;
            m_phi_q       <= m_phi_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            s_ready_q     <= s_ready_d;
            run_count_q   <= run_count_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign core_start  = core_start_q;
    assign core_theta  = core_theta_q;
    assign core_phi    = core_phi_q;
    assign m_valid     = m_valid_q;
    assign m_theta     = m_theta_q;
    assign m_phi       = m_phi_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign run_count   = run_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_kalman_sequencer.sv
// Bench for kalman_sequencer: directed scenarios followed by a random phase.
// A stub core answers each start after a per-run latency; expected outputs
// are derived from the accepted sample order and the stub's latency rules.
module tb_kalman_sequencer;
    import kalman_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int DW      = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_theta = '0;
    logic [DW-1:0] s_phi = '0;
    logic          core_start;
    logic [DW-1:0] core_theta;
    logic [DW-1:0] core_phi;
    logic          core_finish = 1'b0;
    logic [DW-1:0] core_theta_est = '0;
    logic [DW-1:0] core_phi_est = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_theta;
    logic [DW-1:0] m_phi;
    logic          overflow;
    logic          timeout_err;
    logic          clear_err = 1'b0;
    logic          busy;
    logic [15:0]   run_count;
    seq_state_e    dbg_state;

    kalman_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .W       (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_theta        (s_theta),
        .s_phi          (s_phi),
        .core_start     (core_start),
        .core_theta     (core_theta),
        .core_phi       (core_phi),
        .core_finish    (core_finish),
        .core_theta_est (core_theta_est),
        .core_phi_est   (core_phi_est),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_theta        (m_theta),
        .m_phi          (m_phi),
        .overflow       (overflow),
        .timeout_err    (timeout_err),
        .clear_err      (clear_err),
        .busy           (busy),
        .run_count      (run_count),
        .dbg_state      (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] samp_q[$];   // accepted samples awaiting their run
    logic [31:0] exp_q[$];    // estimates expected on the output stream
    int          lat_q[$];    // per-run stub latency, 0 = never finishes
    int          n_acc = 0, n_starts = 0, n_outs = 0;
    int          last_start_cyc = -1, last_out_cyc = -1, tmo_rise_cyc = -1;
    bit          rand_est = 1'b0, rand_lat = 1'b0;
    logic [31:0] fixed_est = '0;
    bit          stub_armed = 1'b0;
    int          stub_fire_cyc = 0;
    logic [31:0] stub_est = '0;
    int          mon_lat;
    logic [31:0] mon_est;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input int target, input int budget, input string tag);
        int n = 0;
        while (n_outs < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n_outs >= target), 1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (n_starts < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n_starts >= target), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_core_start"}, 32'(core_start), 0);
        check({tag, "_core_in"}, {core_theta, core_phi}, 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"}, {m_theta, m_phi}, 0);
        check({tag, "_flags"}, {30'd0, overflow, timeout_err}, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_run_count"}, 32'(run_count), 0);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    // Stub core: drives finish with the run's estimate after its latency
    always @(posedge clk) begin
        #1;
        if (reset) stub_armed = 1'b0;
        if (stub_armed && cyc == stub_fire_cyc) begin
            core_finish = 1'b1;
            {core_theta_est, core_phi_est} = stub_est;
            stub_armed = 1'b0;
        end else begin
            core_finish = 1'b0;
            {core_theta_est, core_phi_est} = $urandom;
        end
    end

    // Scoreboard: input acceptance, run starts and output transfers
    always @(negedge clk) begin
        if (!reset) begin
            if (s_valid && s_ready) begin
                samp_q.push_back({s_theta, s_phi});
                n_acc++;
            end
            if (core_start) begin
                n_starts++;
                last_start_cyc = cyc;
                check("start_has_sample", 32'(samp_q.size() > 0), 1);
                if (samp_q.size() > 0) check("core_inputs", {core_theta, core_phi}, samp_q.pop_front());
                if (lat_q.size() > 0) mon_lat = lat_q.pop_front();
                else mon_lat = rand_lat ? int'($urandom_range(1, 70)) : 40;
                mon_est = rand_est ? $urandom : fixed_est;
                if (mon_lat != 0) begin
                    stub_armed    = 1'b1;
                    stub_fire_cyc = cyc + mon_lat;
                    stub_est      = mon_est;
                end else begin
                    stub_armed = 1'b0;
                end
                // A finish within TIMEOUT wait cycles yields one output
                if (mon_lat != 0 && mon_lat <= TIMEOUT) exp_q.push_back(mon_est);
            end
            if (m_valid && m_ready) begin
                n_outs++;
                last_out_cyc = cyc;
                check("out_has_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("out_data", {m_theta, m_phi}, exp_q.pop_front());
            end
            if (timeout_err && tmo_rise_cyc < 0) tmo_rise_cyc = cyc;
        end
    end

    initial begin
        int c0, s0, o0, a0, st1, st2, out_base, n;
        logic [5:0] rdy;
        bit drained;

        // ---- reset state
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("ready_after_reset", 32'(s_ready), 1);
        tick();

        // ---- single run
        rand_est = 1'b0;
        fixed_est = 32'h0123_0456;
        lat_q.push_back(40);
        s0 = n_starts;
        o0 = n_outs;
        c0 = cyc;
        s_valid = 1'b1;
        s_theta = 16'h1000;
        s_phi = 16'h0800;
        tick();
        s_valid = 1'b0;
        wait_starts(s0 + 1, 20, "single_start_seen");
        check("single_start_cyc", last_start_cyc, c0 + 2);
        check("single_core_hold", {core_theta, core_phi}, 32'h1000_0800);
        wait_outs(o0 + 1, 200, "single_out_seen");
        check("single_out_cyc", last_out_cyc, c0 + 2 + 40 + 2);
        @(negedge clk);
        check("single_mvalid_pulse", 32'(m_valid), 0);
        check("single_out_value", {m_theta, m_phi}, 32'h0123_0456);
        check("single_run_count", 32'(run_count), 1);
        tick();

        // ---- burst of 6 into a depth-4 FIFO
        rand_est = 1'b1;
        a0 = n_acc;
        o0 = n_outs;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_theta = DW'($urandom);
            s_phi = DW'($urandom);
            @(negedge clk);
            rdy[i] = s_ready;
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        check("burst_accepted", n_acc - a0, 5);
        check("burst_ready_pattern", 32'(rdy), 32'b011111);
        check("burst_overflow", 32'(overflow), 1);
        tick();
        wait_outs(o0 + 5, 600, "burst_outs_seen");
        check("burst_exp_empty", exp_q.size(), 0);
        pulse_clear();
        @(negedge clk);
        check("burst_overflow_cleared", 32'(overflow), 0);
        tick();

        // ---- back-pressure over three samples
        m_ready = 1'b0;
        s0 = n_starts;
        o0 = n_outs;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_theta = DW'($urandom);
            s_phi = DW'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (97) tick();
        @(negedge clk);
        check("bp_starts", n_starts - s0, 2);
        check("bp_no_outs", n_outs - o0, 0);
        check("bp_mvalid_held", 32'(m_valid), 1);
        check("bp_busy_in_drain", 32'(busy), 1);
        tick();
        m_ready = 1'b1;
        wait_outs(o0 + 3, 300, "bp_outs_seen");
        check("bp_total_starts", n_starts - s0, 3);

        // ---- watchdog abort, then the next queued sample runs
        tmo_rise_cyc = -1;
        lat_q.push_back(0);
        lat_q.push_back(40);
        s0 = n_starts;
        o0 = n_outs;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_theta = DW'($urandom);
            s_phi = DW'($urandom);
            tick();
        end
        s_valid = 1'b0;
        wait_starts(s0 + 1, 20, "wd_first_start");
        st1 = last_start_cyc;
        wait_starts(s0 + 2, 150, "wd_second_start");
        st2 = last_start_cyc;
        check("wd_restart_cyc", st2, st1 + TIMEOUT + 2);
        check("wd_err_rise_cyc", tmo_rise_cyc, st1 + TIMEOUT + 1);
        wait_outs(o0 + 1, 200, "wd_out_seen");
        repeat (10) tick();
        check("wd_single_output", n_outs - o0, 1);
        check("wd_err_sticky", 32'(timeout_err), 1);
        pulse_clear();
        @(negedge clk);
        check("wd_err_cleared", 32'(timeout_err), 0);
        tick();

        // ---- finish arrives on the watchdog's last cycle
        tmo_rise_cyc = -1;
        lat_q.push_back(TIMEOUT);
        s0 = n_starts;
        o0 = n_outs;
        s_valid = 1'b1;
        s_theta = DW'($urandom);
        s_phi = DW'($urandom);
        tick();
        s_valid = 1'b0;
        wait_starts(s0 + 1, 20, "edge_start");
        st1 = last_start_cyc;
        wait_outs(o0 + 1, 200, "edge_out_seen");
        check("edge_out_cyc", last_out_cyc, st1 + TIMEOUT + 2);
        check("edge_no_timeout", 32'(timeout_err), 0);
        check("edge_no_err_rise", tmo_rise_cyc, -1);

        // ---- reset in the middle of a run with three samples queued
        s0 = n_starts;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_theta = DW'($urandom);
            s_phi = DW'($urandom);
            tick();
        end
        s_valid = 1'b0;
        wait_starts(s0 + 1, 20, "rst_first_start");
        repeat (10) tick();
        reset = 1'b1;
        samp_q.delete();
        exp_q.delete();
        lat_q.delete();
        repeat (2) tick();
        @(negedge clk);
        check_all_zero("midrun_reset");
        tick();
        reset = 1'b0;
        out_base = n_outs;
        s0 = n_starts;
        repeat (30) tick();
        check("rst_no_start", n_starts - s0, 0);
        check("rst_idle", 32'(busy), 0);
        check("rst_ready", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_theta = DW'($urandom);
        s_phi = DW'($urandom);
        tick();
        s_valid = 1'b0;
        wait_outs(out_base + 1, 200, "rst_new_run");
        check("rst_run_count", 32'(run_count), 1);

        // ---- random phase
        rand_lat = 1'b1;
        rand_est = 1'b1;
        a0 = n_acc;
        s0 = n_starts;
        n = 0;
        while ((n_acc - a0) < 40 && n < 4000) begin
            s_valid = ($urandom_range(0, 2) == 0);
            s_theta = DW'($urandom);
            s_phi = DW'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 3000 && !drained; i++) begin
            tick();
            drained = (exp_q.size() == 0) && (samp_q.size() == 0) && !busy && !m_valid;
        end
        check("rnd_drained", 32'(drained), 1);
        check("rnd_starts_match_accepts", n_starts - s0, n_acc - a0);
        check("rnd_run_count", 32'(run_count), 32'((n_outs - out_base) & 16'hFFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
